mem_data_port: RTL and testbench
================================

# mem_data_port

Memory-stage data-memory initiator for the pipelined RV32I core. It turns the load or store held in the EX/MEM register into a single word-aligned request on the data-cache port, with byte mask and lane-replicated store data. It stalls the pipeline until the response arrives and holds the raw load word for the MEM/WB register. The writeback stage's load decode (lb/lh/lw/lbu/lhu) consumes that raw word together with `addr[1:0]`, so this block does no load sign or zero extension.

## Interface
Parameters:
- None. Widths are fixed by `rv32i_types`: 32-bit data and address, 4-bit byte mask.

Ports (one clock; reset is asynchronous and active-high):
- `clk` input 1: core clock. Everything is sampled on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `valid_i` input 1: the EX/MEM register holds a valid instruction.
- `opcode` input `rv32i_opcode`: opcode of the instruction in MEM.
- `funct3` input 3: access size (000 = b, 001 = h, 010 = w, 100 = bu, 101 = hu).
- `addr` input 32: effective address (`alu_out`).
- `rs2_data` input 32: store source.
- `advance_i` input 1: the MEM/WB register loads this cycle.
- `flush_i` input 1: the instruction in MEM is squashed.
- `data_read` output 1: read request.
- `data_write` output 1: write request.
- `data_address` output 32: `{addr[31:2], 2'b00}`.
- `data_wdata` output 32: store data, replicated across lanes.
- `data_mbe` output 4: byte enable.
- `data_resp` input 1: one-cycle completion pulse from the cache.
- `data_rdata` input 32: read data, valid while `data_resp` is high.
- `stall_o` output 1: freeze the IF through MEM stages.
- `rdata_o` output 32: captured raw load word.
- `misaligned_o` output 1: the current access is misaligned and was not issued.

## Operation
- A memory op is `valid_i && (opcode == op_load || opcode == op_store) && !flush_i`.
- Misaligned access:
  - Halfword with `addr[0] = 1`, or word with `addr[1:0] != 0`.
  - `misaligned_o` = 1 combinationally; no request is issued; the access does not stall.
- Byte mask:
  - Byte: `4'b0001 << addr[1:0]`.
  - Halfword: `4'b0011 << {addr[1], 1'b0}`.
  - Word: `4'b1111`.
- Store data:
  - Byte: `{4{rs2_data[7:0]}}`.
  - Halfword: `{2{rs2_data[15:0]}}`.
  - Word: `rs2_data`.
- Address, mask and write data are registered when the request launches and held stable until `data_resp`.
- State machine:
  - IDLE: on an aligned memory op, launch the request (register address, mask and data; set `data_read` for a load or `data_write` for a store) and go to BUSY.
  - BUSY: requests are held. On `data_resp`: drop both requests; for a load, capture `data_rdata` into `rdata_o`; go to DONE, or go to IDLE if a flush was recorded during BUSY.
  - DONE: hold `rdata_o`. Go to IDLE on `advance_i` or `flush_i`.
- `stall_o` = (memory op and aligned and state != DONE) or state == BUSY.
- `flush_i` in BUSY does not abort the bus transaction; it is recorded in a sticky flag that is cleared when leaving BUSY.
- `data_resp` in IDLE or DONE is ignored.
- Outputs after reset: all outputs 0, state IDLE, flush flag 0.
- Reset asserted mid-transaction returns to IDLE with requests low immediately; the cache is reset by the same `rst`.

## Timing
- Cycle 0: op present in MEM with `stall_o` = 1.
- Edge 0→1: request launches; `data_read` or `data_write` is high from cycle 1.
- Response at cycle k (k ≥ 1): data is captured at the end of cycle k; requests are low and `stall_o` is 0 from cycle k+1.
- Minimum load latency is therefore 2 stall cycles.
- Back-to-back memory ops: DONE→IDLE on `advance_i`; the next op launches one cycle later, so there is no overlap and at most one outstanding request.
- Requests are never asserted in the same cycle that `data_resp` is consumed.

## Structure
- Add a `mem_state_t` enum (IDLE, BUSY, DONE) and `mbe_t` (logic [3:0]) to package `control`.
- Size encodings come from the existing `funct3` definitions in `rv32i_types`.
- One combinational sub-module, `store_align`: inputs `funct3`, `addr[1:0]` and `rs2_data`; outputs `mbe`, `wdata` and `misaligned`.
- FSM, capture registers and stall logic live in the top module.

## Test plan
- `sw` to `0x100`, `rs2` = `0xDEADBEEF`, `data_resp` at cycle 3 → `data_write` high in cycles 1–3, `data_mbe` = `4'hF`, `data_address` = `0x100`, `stall_o` low from cycle 4.
- `sb` to `0x203`, `rs2` = `0x12345678` → `data_mbe` = `4'b1000`, `data_wdata` = `0x78787878`, `data_address` = `0x200`.
- `lh` from `0x302`, `data_rdata` = `0xAABBCCDD` at cycle 1 → `data_mbe` = `4'b1100`; `rdata_o` = `0xAABBCCDD` and held through DONE until `advance_i`.
- `lw` from `0x101` → `misaligned_o` = 1, no request, `stall_o` = 0.
- Load with `flush_i` in cycle 2 and `data_resp` in cycle 4 → requests drop after cycle 4, state returns to IDLE (not DONE), `stall_o` = 0 from cycle 5.
- `rst` asserted in BUSY → `data_read` = 0 immediately, state IDLE; a later `data_resp` is ignored.

Source files
------------

// File: rtl/mem_data_port_pkg.sv
// Shared types for the memory-stage data port: opcodes, access-size encodings,
// port FSM states and the byte-mask type.
package mem_data_port_pkg;

   typedef enum logic [6:0] {
      op_lui   = 7'b0110111,
      op_auipc = 7'b0010111,
      op_jal   = 7'b1101111,
      op_jalr  = 7'b1100111,
      op_br    = 7'b1100011,
      op_load  = 7'b0000011,
      op_store = 7'b0100011,
      op_imm   = 7'b0010011,
      op_reg   = 7'b0110011,
      op_csr   = 7'b1110011
   } rv32i_opcode;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } mem_state_t;

   typedef logic [3:0] mbe_t;

   function automatic logic is_mem_op(input rv32i_opcode op);
      return (op == op_load) || (op == op_store);
   endfunction

endpackage

// File: rtl/mem_data_port_store_align.sv
// Combinational size decode: byte mask, lane-replicated store data and
// alignment check for one load/store.
module store_align
   import mem_data_port_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  offset,
   input  logic [31:0] rs2_data,
   output mbe_t        mbe,
   output logic [31:0] wdata,
   output logic        misaligned
);

   // Reserved size encodings are flagged misaligned so they never reach the bus.
   always_comb begin
      mbe        = 4'b0000;
      wdata      = rs2_data;
      misaligned = 1'b0;
      case (funct3)
         F3_B, F3_BU: begin
            mbe   = 4'b0001 << offset;
            wdata = {4{rs2_data[7:0]}};
         end
         F3_H, F3_HU: begin
            mbe        = 4'b0011 << {offset[1], 1'b0};
            wdata      = {2{rs2_data[15:0]}};
            misaligned = offset[0];
         end
         F3_W: begin
            mbe        = 4'b1111;
            misaligned = (offset != 2'b00);
         end
         default: begin
            mbe        = 4'b0000;
            misaligned = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/mem_data_port.sv
// Memory-stage data-cache initiator: issues one word-aligned request per
// load/store, stalls until the response and holds the raw load word.
module mem_data_port
   import mem_data_port_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        valid_i,
   input  rv32i_opcode opcode,
   input  logic [2:0]  funct3,
   input  logic [31:0] addr,
   input  logic [31:0] rs2_data,
   input  logic        advance_i,
   input  logic        flush_i,
   output logic        data_read,
   output logic        data_write,
   output logic [31:0] data_address,
   output logic [31:0] data_wdata,
   output logic [3:0]  data_mbe,
   input  logic        data_resp,
   input  logic [31:0] data_rdata,
   output logic        stall_o,
   output logic [31:0] rdata_o,
   output logic        misaligned_o
);

   mem_state_t  state;
   mem_state_t  state_next;
   logic        flush_seen;
   logic        mem_op;
   logic        mis;
   mbe_t        mbe;
   logic [31:0] wdata;
   logic        launch;
   logic        complete;

   store_align u_store_align (
      .funct3     (funct3),
      .offset     (addr[1:0]),
      .rs2_data   (rs2_data),
      .mbe        (mbe),
      .wdata      (wdata),
      .misaligned (mis)
   );

   assign mem_op = valid_i && is_mem_op(opcode) && !flush_i;

   // FSM state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // FSM next-state logic
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (launch) state_next = BUSY;
            else        state_next = IDLE;
         end
         BUSY: begin
            if (data_resp) state_next = (flush_seen || flush_i) ? IDLE : DONE;
            else           state_next = BUSY;
         end
         DONE: begin
            if (advance_i || flush_i) state_next = IDLE;
            else                      state_next = DONE;
         end
         default: state_next = IDLE;
      endcase
   end

   // FSM outputs: launch/complete strobes, stall and misalignment report
   always_comb begin
      launch       = (state == IDLE) && mem_op && !mis;
      complete     = (state == BUSY) && data_resp;
      stall_o      = (mem_op && !mis && (state != DONE)) || (state == BUSY);
      misaligned_o = mem_op && mis;
   end

   // A squash during BUSY cannot abort the bus cycle, so remember it until the response
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         flush_seen <= 1'b0;
      end else if ((state == BUSY) && !complete) begin
         flush_seen <= flush_seen || flush_i;
      end else begin
         flush_seen <= 1'b0;
      end
   end

   // Request registers: captured at launch, held until the response
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_read    <= 1'b0;
         data_write   <= 1'b0;
         data_address <= 32'h0000_0000;
         data_wdata   <= 32'h0000_0000;
         data_mbe     <= 4'b0000;
      end else if (launch) begin
         data_read    <= (opcode == op_load);
         data_write   <= (opcode == op_store);
         data_address <= {addr[31:2], 2'b00};
         data_wdata   <= wdata;
         data_mbe     <= mbe;
      end else if (complete) begin
         data_read    <= 1'b0;
         data_write   <= 1'b0;
      end
   end

   // Raw load word for MEM/WB; extension happens in writeback
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdata_o <= 32'h0000_0000;
      end else if (complete && data_read) begin
         rdata_o <= data_rdata;
      end
   end

endmodule

// File: tb/tb_mem_data_port.sv
// Self-checking bench for mem_data_port: directed vector table, reset and
// idle corner cases, then randomized transactions against a size/alignment model.
module tb_mem_data_port;
   import mem_data_port_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        valid_i;
   rv32i_opcode opcode;
   logic [2:0]  funct3;
   logic [31:0] addr;
   logic [31:0] rs2_data;
   logic        advance_i;
   logic        flush_i;
   logic        data_read;
   logic        data_write;
   logic [31:0] data_address;
   logic [31:0] data_wdata;
   logic [3:0]  data_mbe;
   logic        data_resp;
   logic [31:0] data_rdata;
   logic        stall_o;
   logic [31:0] rdata_o;
   logic        misaligned_o;

   int errors = 0;
   int checks = 0;
   logic [31:0] exp_rdata = 32'h0;

   always #5 clk = ~clk;

   mem_data_port dut (
      .clk          (clk),
      .rst          (rst),
      .valid_i      (valid_i),
      .opcode       (opcode),
      .funct3       (funct3),
      .addr         (addr),
      .rs2_data     (rs2_data),
      .advance_i    (advance_i),
      .flush_i      (flush_i),
      .data_read    (data_read),
      .data_write   (data_write),
      .data_address (data_address),
      .data_wdata   (data_wdata),
      .data_mbe     (data_mbe),
      .data_resp    (data_resp),
      .data_rdata   (data_rdata),
      .stall_o      (stall_o),
      .rdata_o      (rdata_o),
      .misaligned_o (misaligned_o)
   );

   typedef struct {
      rv32i_opcode op;
      logic [2:0]  f3;
      logic [31:0] a;
      logic [31:0] rs2;
      logic [31:0] rd;
      int          lat;
      int          flush_at;
      int          hold;
      logic [3:0]  mbe;
      logic [31:0] wdata;
      logic        mis;
   } vec_t;

   vec_t tbl[9];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: access size in bytes from funct3
   function automatic int size_bytes(input logic [2:0] f3);
      case (f3[1:0])
         2'b00:   return 1;
         2'b01:   return 2;
         default: return 4;
      endcase
   endfunction

   task automatic run_txn(input rv32i_opcode op, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] rs2, input logic [31:0] rd, input int lat,
                          input int flush_at, input int hold, input logic [3:0] e_mbe,
                          input logic [31:0] e_wdata, input logic e_mis);
      logic is_load;
      logic flushed;
      is_load = (op == op_load);
      flushed = 1'b0;
      @(posedge clk); #1;
      valid_i = 1'b1; opcode = op; funct3 = f3; addr = a; rs2_data = rs2;
      advance_i = 1'b0; flush_i = 1'b0; data_resp = 1'b0;
      @(negedge clk);
      chk("misaligned_c0", 32'(misaligned_o), 32'(e_mis));
      chk("stall_c0", 32'(stall_o), 32'(!e_mis));
      chk("req_c0", 32'({data_read, data_write}), 32'd0);
      if (e_mis) begin
         @(posedge clk); #1;
         valid_i = 1'b0;
         @(negedge clk);
         chk("no_req_misaligned", 32'({data_read, data_write}), 32'd0);
         return;
      end
      for (int c = 1; c <= lat; c++) begin
         @(posedge clk); #1;
         flush_i = (c == flush_at);
         if (c == flush_at) begin
            flushed = 1'b1;
            valid_i = 1'b0;
         end
         data_resp  = (c == lat);
         data_rdata = (c == lat) ? rd : $urandom;
         @(negedge clk);
         chk("data_read", 32'(data_read), 32'(is_load));
         chk("data_write", 32'(data_write), 32'(!is_load));
         chk("data_address", data_address, {a[31:2], 2'b00});
         chk("data_mbe", 32'(data_mbe), 32'(e_mbe));
         chk("data_wdata", data_wdata, e_wdata);
         chk("stall_busy", 32'(stall_o), 32'd1);
      end
      if (is_load) exp_rdata = rd;
      @(posedge clk); #1;
      data_resp = 1'b0; flush_i = 1'b0; data_rdata = $urandom;
      @(negedge clk);
      chk("req_after_resp", 32'({data_read, data_write}), 32'd0);
      chk("stall_after_resp", 32'(stall_o), 32'd0);
      chk("rdata_o", rdata_o, exp_rdata);
      if (!flushed) begin
         for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            data_resp = (h == 0); // stray response in DONE must be ignored
            data_rdata = $urandom;
            @(negedge clk);
            chk("rdata_hold", rdata_o, exp_rdata);
            chk("stall_done", 32'(stall_o), 32'd0);
            chk("req_done", 32'({data_read, data_write}), 32'd0);
         end
         @(posedge clk); #1;
         data_resp = 1'b0; advance_i = 1'b1;
         @(posedge clk); #1;
         advance_i = 1'b0; valid_i = 1'b0;
         @(negedge clk);
         chk("stall_after_adv", 32'(stall_o), 32'd0);
         chk("rdata_after_adv", rdata_o, exp_rdata);
      end
   endtask

   initial begin
      logic [2:0]  f3_list[5];
      rv32i_opcode op;
      logic [2:0]  f3;
      logic [31:0] a;
      logic [31:0] rs2;
      logic [31:0] rd;
      int          n;
      int          lat;
      int          fl;
      logic [3:0]  e_mbe;
      logic [31:0] e_wdata;
      logic        e_mis;

      f3_list = '{F3_B, F3_H, F3_W, F3_BU, F3_HU};
      tbl[0] = '{op_store, F3_W,  32'h0000_0100, 32'hDEAD_BEEF, 32'h0,          3, 0, 1, 4'b1111, 32'hDEAD_BEEF, 1'b0};
      tbl[1] = '{op_store, F3_B,  32'h0000_0203, 32'h1234_5678, 32'h0,          2, 0, 0, 4'b1000, 32'h7878_7878, 1'b0};
      tbl[2] = '{op_load,  F3_H,  32'h0000_0302, 32'h1111_2222, 32'hAABB_CCDD,  1, 0, 3, 4'b1100, 32'h2222_2222, 1'b0};
      tbl[3] = '{op_load,  F3_W,  32'h0000_0101, 32'h0,         32'h0,          1, 0, 0, 4'b0000, 32'h0,         1'b1};
      tbl[4] = '{op_load,  F3_W,  32'h0000_0400, 32'hCAFE_F00D, 32'h55AA_55AA,  4, 2, 0, 4'b1111, 32'hCAFE_F00D, 1'b0};
      tbl[5] = '{op_load,  F3_BU, 32'h0000_0001, 32'h0000_00A5, 32'h0102_0304,  2, 0, 1, 4'b0010, 32'hA5A5_A5A5, 1'b0};
      tbl[6] = '{op_load,  F3_HU, 32'h0000_0001, 32'h0,         32'h0,          1, 0, 0, 4'b0000, 32'h0,         1'b1};
      tbl[7] = '{op_store, F3_H,  32'h0000_0006, 32'hFFFF_8001, 32'h0,          2, 0, 0, 4'b1100, 32'h8001_8001, 1'b0};
      tbl[8] = '{op_store, F3_W,  32'h0000_000C, 32'h0BAD_CAFE, 32'h0,          1, 1, 0, 4'b1111, 32'h0BAD_CAFE, 1'b0};

      rst = 1'b1; valid_i = 1'b0; opcode = op_reg; funct3 = 3'b000; addr = 32'h0;
      rs2_data = 32'h0; advance_i = 1'b0; flush_i = 1'b0; data_resp = 1'b0; data_rdata = 32'h0;
      #12;
      chk("reset_req", 32'({data_read, data_write}), 32'd0);
      chk("reset_addr", data_address, 32'h0);
      chk("reset_mbe", 32'(data_mbe), 32'd0);
      chk("reset_rdata", rdata_o, 32'h0);
      chk("reset_stall", 32'(stall_o), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      for (int i = 0; i < 9; i++) begin
         run_txn(tbl[i].op, tbl[i].f3, tbl[i].a, tbl[i].rs2, tbl[i].rd, tbl[i].lat,
                 tbl[i].flush_at, tbl[i].hold, tbl[i].mbe, tbl[i].wdata, tbl[i].mis);
      end

      // Non-memory op with an odd address is neither a request nor misaligned
      @(posedge clk); #1;
      valid_i = 1'b1; opcode = op_reg; funct3 = F3_W; addr = 32'h0000_0101;
      @(negedge clk);
      chk("nonmem_mis", 32'(misaligned_o), 32'd0);
      chk("nonmem_stall", 32'(stall_o), 32'd0);
      @(posedge clk); #1;
      valid_i = 1'b0; data_resp = 1'b1; data_rdata = 32'h7777_7777;
      @(posedge clk); #1;
      data_resp = 1'b0;
      @(negedge clk);
      chk("idle_resp_req", 32'({data_read, data_write}), 32'd0);
      chk("idle_resp_rdata", rdata_o, exp_rdata);

      // Reset in the middle of a load, then a late response
      @(posedge clk); #1;
      valid_i = 1'b1; opcode = op_load; funct3 = F3_W; addr = 32'h0000_0500;
      @(posedge clk); #1;
      valid_i = 1'b0;
      @(negedge clk);
      chk("pre_rst_read", 32'(data_read), 32'd1);
      #1 rst = 1'b1;
      #1;
      chk("rst_read", 32'(data_read), 32'd0);
      chk("rst_stall", 32'(stall_o), 32'd0);
      exp_rdata = 32'h0;
      @(posedge clk); #1;
      rst = 1'b0; data_resp = 1'b1; data_rdata = 32'h9999_9999;
      @(posedge clk); #1;
      data_resp = 1'b0;
      @(negedge clk);
      chk("late_resp_req", 32'({data_read, data_write}), 32'd0);
      chk("late_resp_rdata", rdata_o, exp_rdata);
      chk("late_resp_stall", 32'(stall_o), 32'd0);

      for (int t = 0; t < 60; t++) begin
         op  = ($urandom_range(0, 1) == 0) ? op_load : op_store;
         f3  = f3_list[$urandom_range(0, 4)];
         a   = $urandom;
         rs2 = $urandom;
         rd  = $urandom;
         lat = $urandom_range(1, 4);
         fl  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, lat) : 0;
         n   = size_bytes(f3);
         e_mis = ((a % n) != 0);
         e_mbe = 4'(((1 << n) - 1) << (a % 4));
         case (n)
            1:       e_wdata = rs2[7:0] * 32'h0101_0101;
            2:       e_wdata = rs2[15:0] * 32'h0001_0001;
            default: e_wdata = rs2;
         endcase
         run_txn(op, f3, a, rs2, rd, lat, fl, $urandom_range(0, 2), e_mbe, e_wdata, e_mis);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
